// File: rtl/reg8.sv
// Load-enabled data register with synchronous clear, a sticky valid flag and a write-ack pulse.
// Used as the accumulator of the simple CPU datapath.
module reg8 #(
  parameter int unsigned       WIDTH   = 8,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wen_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             valid_o,
  output logic             wr_ack_o
);

  logic [WIDTH-1:0] q_d, q_q;
  logic             valid_d, valid_q;
  logic             wr_ack_d, wr_ack_q;

  // Priority: clear over write over hold; reset is applied in the flop block.
  always_comb begin
    q_d      = q_q;
    valid_d  = valid_q;
    wr_ack_d = 1'b0;
    if (clr_i) begin
      q_d     = RST_VAL;
      valid_d = 1'b0;
    end else if (wen_i) begin
      q_d      = d_i;
      valid_d  = 1'b1;
      wr_ack_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      q_q      <= RST_VAL;
      valid_q  <= 1'b0;
      wr_ack_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      valid_q  <= valid_d;
      wr_ack_q <= wr_ack_d;
    end
  end

  assign q_o      = q_q;
  assign valid_o  = valid_q;
  assign wr_ack_o = wr_ack_q;

endmodule

// File: tb/tb_reg8.sv
// Directed bench for reg8: a reference model pushes expected outputs per edge into a
// scoreboard queue, which is popped and compared one cycle later.
module tb_reg8;

  logic       clk_i = 1'b0;
  logic       rst_i, wen_i, clr_i;
  logic [7:0] d_i;
  logic [7:0] q_o;
  logic       valid_o, wr_ack_o;

  reg8 dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wen_i    (wen_i),
    .clr_i    (clr_i),
    .d_i      (d_i),
    .q_o      (q_o),
    .valid_o  (valid_o),
    .wr_ack_o (wr_ack_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [7:0] q;
    logic       v;
    logic       a;
  } exp_t;

  exp_t       sb[$];
  int         tests = 0;
  int         fails = 0;
  logic [7:0] mq;
  logic       mv, ma;

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, predict the post-edge state, then compare after the edge.
  task automatic step(input string tag, input logic rst, input logic clr, input logic wen,
                      input logic [7:0] d);
    exp_t e;
    rst_i = rst;
    clr_i = clr;
    wen_i = wen;
    d_i   = d;
    if (!rst) begin
      mq = 8'h00; mv = 1'b0; ma = 1'b0;
    end else if (clr) begin
      mq = 8'h00; mv = 1'b0; ma = 1'b0;
    end else if (wen) begin
      mq = d; mv = 1'b1; ma = 1'b1;
    end else begin
      ma = 1'b0;
    end
    sb.push_back('{q: mq, v: mv, a: ma});
    @(posedge clk_i);
    #1;
    tests++;
    assert (sb.size() == 1) else begin
      fails++;
      $error("FAIL %s_sb: observed depth %0d expected 1", tag, sb.size());
    end
    e = sb.pop_front();
    chk8({tag, "_q"}, q_o, e.q);
    chk1({tag, "_valid"}, valid_o, e.v);
    chk1({tag, "_ack"}, wr_ack_o, e.a);
  endtask

  initial begin
    mq = 8'h00; mv = 1'b0; ma = 1'b0;
    rst_i = 1'b1; clr_i = 1'b0; wen_i = 1'b0; d_i = 8'h00;
    @(negedge clk_i);

    step("reset", 1'b0, 1'b0, 1'b0, 8'h00);
    chk8("reset_const_q", q_o, 8'h00);

    step("load", 1'b1, 1'b0, 1'b1, 8'hCC);
    chk8("load_const_q", q_o, 8'hCC);
    chk1("load_const_ack", wr_ack_o, 1'b1);

    for (int i = 0; i < 3; i++) step("hold", 1'b1, 1'b0, 1'b0, 8'hFF);
    chk8("hold_const_q", q_o, 8'hCC);

    step("overwrite", 1'b1, 1'b0, 1'b1, 8'hFF);
    chk8("overwrite_const_q", q_o, 8'hFF);

    step("same_val", 1'b1, 1'b0, 1'b1, 8'hFF);
    step("rst_vs_wen", 1'b0, 1'b0, 1'b1, 8'h5A);
    step("resume", 1'b1, 1'b0, 1'b1, 8'h77);
    step("clr_vs_wen", 1'b1, 1'b1, 1'b1, 8'h33);
    chk1("clr_const_valid", valid_o, 1'b0);
    step("clr_hold", 1'b1, 1'b0, 1'b0, 8'h44);
    step("rst_vs_clr", 1'b0, 1'b1, 1'b1, 8'h99);

    step("stream0", 1'b1, 1'b0, 1'b1, 8'h01);
    step("stream1", 1'b1, 1'b0, 1'b1, 8'h02);
    step("stream2", 1'b1, 1'b0, 1'b1, 8'h80);
    step("stream3", 1'b1, 1'b0, 1'b1, 8'hFE);
    chk1("stream_const_ack", wr_ack_o, 1'b1);
    step("stream_end", 1'b1, 1'b0, 1'b0, 8'h00);
    chk8("stream_end_q", q_o, 8'hFE);

    for (int i = 0; i < 40; i++)
      step("rand", ($urandom_range(0, 9) != 0), ($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 1)), 8'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
